// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file writeback scheduler.
package regfile_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0] reg_addr_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; the pointer names the source that wins
// the next contested cycle and only moves when both sources request.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_alu,
    input  logic req_lsu,
    output logic gnt_alu,
    output logic gnt_lsu
);

    wb_src_e prio_q;
    wb_src_e prio_d;

    always_comb begin
        gnt_alu = 1'b0;
        gnt_lsu = 1'b0;
        prio_d  = prio_q;
        if (req_alu && req_lsu) begin
            if (prio_q == WB_ALU) begin
                gnt_alu = 1'b1;
                prio_d  = WB_LSU;
            end else begin
                gnt_lsu = 1'b1;
                prio_d  = WB_ALU;
            end
        end else begin
            gnt_alu = req_alu;
            gnt_lsu = req_lsu;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= WB_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler and scoreboard: arbitrates ALU/LSU results onto the
// single register-file write port and stalls issue on RAW/WAW hazards.
module regfile_wb_sched
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            alu_wb_valid,
    input  logic [AW-1:0]   alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    output logic            alu_wb_ready,
    input  logic            lsu_wb_valid,
    input  logic [AW-1:0]   lsu_wb_rd,
    input  logic [XLEN-1:0] lsu_wb_data,
    output logic            lsu_wb_ready,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] busy_vec,
    output logic            wb_err
);

    logic            issue_fire;
    logic            wb_fire;
    reg_addr_t       wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            rf_wen_q,   rf_wen_d;
    reg_addr_t       rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            wb_err_q,   wb_err_d;

    // Hazard check deliberately sees only the registered scoreboard.
    assign issue_ready = !busy_vec[issue_rs1] && !busy_vec[issue_rs2] && !busy_vec[issue_rd];
    assign issue_fire  = issue_valid && issue_ready;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_alu (alu_wb_valid),
        .req_lsu (lsu_wb_valid),
        .gnt_alu (alu_wb_ready),
        .gnt_lsu (lsu_wb_ready)
    );

    always_comb begin
        wb_fire = alu_wb_ready || lsu_wb_ready;
        wb_rd   = alu_wb_ready ? alu_wb_rd   : lsu_wb_rd;
        wb_data = alu_wb_ready ? alu_wb_data : lsu_wb_data;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_x0
                assign busy_vec[gi] = 1'b0;
            end else begin : g_xn
                logic busy_bit_q;
                logic busy_bit_d;

                // Clear on commit first so a simultaneous issue set wins.
                always_comb begin
                    busy_bit_d = busy_bit_q;
                    if (rf_wen_q && (rf_waddr_q == AW'(gi))) begin
                        busy_bit_d = 1'b0;
                    end
                    if (issue_fire && (issue_rd == AW'(gi))) begin
                        busy_bit_d = 1'b1;
                    end
                end

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        busy_bit_q <= 1'b0;
                    end else begin
                        busy_bit_q <= busy_bit_d;
                    end
                end

                assign busy_vec[gi] = busy_bit_q;
            end
        end
    endgenerate

    // Writes to x0 complete the handshake but never reach the register file.
    always_comb begin
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        wb_err_d   = wb_err_q;
        if (wb_fire && (wb_rd != '0)) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = wb_rd;
            rf_wdata_d = wb_data;
            if (!busy_vec[wb_rd]) begin
                wb_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed plus randomized checks of regfile_wb_sched against a cycle model.
module tb_regfile_wb_sched;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_ready;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [63:0] alu_wb_data;
    logic        alu_wb_ready;
    logic        lsu_wb_valid;
    logic [4:0]  lsu_wb_rd;
    logic [63:0] lsu_wb_data;
    logic        lsu_wb_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [31:0] busy_vec;
    logic        wb_err;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference state: which registers have a write pending, what the write
    // port shows, the sticky error, and who lost the last contested cycle.
    logic [31:0] busy_m;
    logic        wen_m;
    logic [4:0]  waddr_m;
    logic [63:0] wdata_m;
    logic        err_m;
    bit          lsu_turn_m;

    regfile_wb_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_rd    (alu_wb_rd),
        .alu_wb_data  (alu_wb_data),
        .alu_wb_ready (alu_wb_ready),
        .lsu_wb_valid (lsu_wb_valid),
        .lsu_wb_rd    (lsu_wb_rd),
        .lsu_wb_data  (lsu_wb_data),
        .lsu_wb_ready (lsu_wb_ready),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .busy_vec     (busy_vec),
        .wb_err       (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid  = 1'b0;
        issue_rs1    = '0;
        issue_rs2    = '0;
        issue_rd     = '0;
        alu_wb_valid = 1'b0;
        alu_wb_rd    = '0;
        alu_wb_data  = '0;
        lsu_wb_valid = 1'b0;
        lsu_wb_rd    = '0;
        lsu_wb_data  = '0;
    endtask

    // One clock cycle: check the combinational handshakes against the model,
    // advance the model, cross the edge, then check the registered outputs.
    task automatic tick();
        logic        exp_ir;
        bit          g_alu, g_lsu;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [31:0] n_busy;
        #1;
        exp_ir = !busy_m[issue_rs1] && !busy_m[issue_rs2] && !busy_m[issue_rd];
        g_alu  = alu_wb_valid && (!lsu_wb_valid || !lsu_turn_m);
        g_lsu  = lsu_wb_valid && (!alu_wb_valid || lsu_turn_m);
        chk("issue_ready", issue_ready, exp_ir);
        chk("alu_wb_ready", alu_wb_ready, g_alu);
        chk("lsu_wb_ready", lsu_wb_ready, g_lsu);
        chk("one_ready", alu_wb_ready && lsu_wb_ready, 1'b0);

        if (!rst_n) begin
            busy_m     = '0;
            wen_m      = 1'b0;
            waddr_m    = '0;
            wdata_m    = '0;
            err_m      = 1'b0;
            lsu_turn_m = 1'b0;
        end else begin
            n_busy = busy_m;
            if (wen_m) n_busy[waddr_m] = 1'b0;
            if (issue_valid && exp_ir && issue_rd != 5'd0) n_busy[issue_rd] = 1'b1;
            wen_m = 1'b0;
            if (g_alu || g_lsu) begin
                rd   = g_alu ? alu_wb_rd : lsu_wb_rd;
                data = g_alu ? alu_wb_data : lsu_wb_data;
                if (rd != 5'd0) begin
                    wen_m   = 1'b1;
                    waddr_m = rd;
                    wdata_m = data;
                    if (!busy_m[rd]) err_m = 1'b1;
                end
            end
            if (alu_wb_valid && lsu_wb_valid) lsu_turn_m = g_alu;
            busy_m = n_busy;
        end

        @(posedge clk);
        #1;
        chk("rf_wen", rf_wen, wen_m);
        chk("busy_vec", busy_vec, busy_m);
        chk("wb_err", wb_err, err_m);
        if (wen_m || !rst_n) begin
            chk("rf_waddr", rf_waddr, waddr_m);
            chk("rf_wdata", rf_wdata, wdata_m);
        end
        $display("[TB] t=%0t rst_n=%b iss=%b/%0d ar=%b lr=%b wen=%b wa=%0d busy=%h err=%b",
                 $time, rst_n, issue_valid, issue_rd, alu_wb_ready, lsu_wb_ready,
                 rf_wen, rf_waddr, busy_vec, wb_err);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        busy_m = '0; wen_m = 1'b0; waddr_m = '0; wdata_m = '0;
        err_m = 1'b0; lsu_turn_m = 1'b0;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("ready_in_reset", issue_ready, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;

        // Issue x5 <- x1,x2, then a dependent on x5 stalls until writeback commits.
        issue_valid = 1'b1; issue_rd = 5'd5; issue_rs1 = 5'd1; issue_rs2 = 5'd2;
        #1 chk("first_issue_ready", issue_ready, 1'b1);
        tick();
        chk("busy_x5", busy_vec, 32'h0000_0020);
        issue_rs1 = 5'd5; issue_rs2 = 5'd0; issue_rd = 5'd6;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 64'hDEAD_BEEF;
        #1 chk("raw_stall", issue_ready, 1'b0);
        tick();
        chk("wb_wen", rf_wen, 1'b1);
        chk("wb_addr", rf_waddr, 5'd5);
        chk("wb_data", rf_wdata, 64'hDEAD_BEEF);
        alu_wb_valid = 1'b0;
        #1 chk("stall_n1", issue_ready, 1'b0);
        tick();
        chk("busy_cleared", busy_vec, 32'h0);
        #1 chk("accept_n2", issue_ready, 1'b1);
        tick();
        chk("busy_x6", busy_vec, 32'h0000_0040);
        issue_valid = 1'b0;

        // Contested writebacks alternate, starting with ALU.
        issue_valid = 1'b1; issue_rd = 5'd3; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
        tick();
        issue_rd = 5'd4;
        tick();
        issue_valid = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 64'h3333;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd4; lsu_wb_data = 64'h4444;
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_order", alu_wb_ready, (k % 2) == 0);
            tick();
        end
        idle_inputs();

        // Writeback to x0 handshakes without writing.
        do_reset();
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd0; lsu_wb_data = 64'h1234;
        #1 chk("x0_ready", lsu_wb_ready, 1'b1);
        tick();
        chk("x0_no_wen", rf_wen, 1'b0);
        chk("x0_no_err", wb_err, 1'b0);
        idle_inputs();

        // Writeback to a non-busy register is written and flags a sticky error.
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd7; alu_wb_data = 64'h7777;
        tick();
        chk("x7_addr", rf_waddr, 5'd7);
        chk("x7_err", wb_err, 1'b1);
        idle_inputs();
        for (int k = 0; k < 3; k++) tick();
        chk("err_sticky", wb_err, 1'b1);

        // Move the pointer to LSU, then reset during an rf_wen cycle.
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd10;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd11;
        tick();
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd9; alu_wb_data = 64'h9999;
        tick();
        alu_wb_valid = 1'b0;
        chk("x9_wen", rf_wen, 1'b1);
        do_reset();
        chk("rst_wen", rf_wen, 1'b0);
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_err", wb_err, 1'b0);
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd1;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd2;
        #1 chk("rst_ptr_alu", alu_wb_ready, 1'b1);
        tick();
        idle_inputs();

        // Randomized traffic over a small register window to provoke hazards.
        for (int k = 0; k < 600; k++) begin
            rst_n        = ($urandom_range(0, 79) != 0);
            issue_valid  = $urandom_range(0, 1);
            issue_rs1    = 5'($urandom_range(0, 7));
            issue_rs2    = 5'($urandom_range(0, 7));
            issue_rd     = 5'($urandom_range(0, 7));
            alu_wb_valid = ($urandom_range(0, 2) != 0);
            alu_wb_rd    = 5'($urandom_range(0, 7));
            alu_wb_data  = {$urandom, $urandom};
            lsu_wb_valid = ($urandom_range(0, 2) != 0);
            lsu_wb_rd    = 5'($urandom_range(0, 7));
            lsu_wb_data  = {$urandom, $urandom};
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
